// File: rtl/seq_pkg.sv
// Shared definitions for the register-access sequencer: opcodes, FSM states
// and default widths. Optional macro SEQ_SWAP_EN adds the WR2 state used by SWAP.
package seq_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 3;

  localparam logic [1:0] OP_MOV   = 2'b00;
  localparam logic [1:0] OP_COPY  = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Last address written by CLEAR; the counter parks here instead of wrapping
  localparam logic [2:0] CLR_LAST = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    WR1,
    CLR,
    FIN
`ifdef SEQ_SWAP_EN
    , WR2
`endif
  } state_t;

endpackage

// File: rtl/reg_access_seq.sv
// Register-access sequencer: accepts one command at a time and drives an
// external register file (async read, sync write) to perform MOV, COPY, SWAP
// or CLEAR. Every output is registered: the next-output logic looks at the
// next state so outputs line up with the state they belong to.
// Optional macro SEQ_SWAP_EN: when undefined, SWAP is rejected with ERR.
module reg_access_seq
  import seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [ADDR_W-1:0] CMD_DEST,
  input  logic [ADDR_W-1:0] CMD_SRC,
  input  logic [DATA_W-1:0] CMD_IMM,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic              WRITE,
  output logic [DATA_W-1:0] WRITEDATA,
  output logic [ADDR_W-1:0] WRITEREG,
  output logic [ADDR_W-1:0] READREG1,
  output logic [ADDR_W-1:0] READREG2,
  input  logic [DATA_W-1:0] REGOUT1,
  input  logic [DATA_W-1:0] REGOUT2
);

  state_t state, state_nxt;

  logic              accept;
  logic [1:0]        op_q, cur_op;
  logic [ADDR_W-1:0] dest_q, src_q, cur_dest, cur_src;
  logic [DATA_W-1:0] imm_q, cur_imm;
  logic [DATA_W-1:0] cap1_q, cap1_val;
`ifdef SEQ_SWAP_EN
  logic [DATA_W-1:0] cap2_q, cap2_val;
`else
  logic              unused_regout2;
`endif
  logic [2:0]        clr_cnt, clr_cnt_nxt;

  logic              ready_nxt, busy_nxt, done_nxt, err_nxt, write_nxt;
  logic [DATA_W-1:0] wdata_nxt;
  logic [ADDR_W-1:0] wreg_nxt, rr1_nxt, rr2_nxt;

  assign accept = CMD_VALID & CMD_READY;

  // On the acceptance edge the latches are not yet loaded, so bypass them
  assign cur_op   = accept ? CMD_OP   : op_q;
  assign cur_dest = accept ? CMD_DEST : dest_q;
  assign cur_src  = accept ? CMD_SRC  : src_q;
  assign cur_imm  = accept ? CMD_IMM  : imm_q;

  // Read data is taken at the end of CAP, giving the register file a full cycle
  assign cap1_val = (state == CAP) ? REGOUT1 : cap1_q;
`ifdef SEQ_SWAP_EN
  assign cap2_val = (state == CAP) ? REGOUT2 : cap2_q;
`else
  assign unused_regout2 = ^REGOUT2;
`endif

  // State, command latches, capture registers and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      op_q      <= '0;
      dest_q    <= '0;
      src_q     <= '0;
      imm_q     <= '0;
      cap1_q    <= '0;
`ifdef SEQ_SWAP_EN
      cap2_q    <= '0;
`endif
      clr_cnt   <= '0;
      CMD_READY <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      WRITE     <= 1'b0;
      WRITEDATA <= '0;
      WRITEREG  <= '0;
      READREG1  <= '0;
      READREG2  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q   <= CMD_OP;
        dest_q <= CMD_DEST;
        src_q  <= CMD_SRC;
        imm_q  <= CMD_IMM;
      end
      if (state == CAP) begin
        cap1_q <= REGOUT1;
`ifdef SEQ_SWAP_EN
        cap2_q <= REGOUT2;
`endif
      end
      clr_cnt   <= clr_cnt_nxt;
      CMD_READY <= ready_nxt;
      BUSY      <= busy_nxt;
      DONE      <= done_nxt;
      ERR       <= err_nxt;
      WRITE     <= write_nxt;
      WRITEDATA <= wdata_nxt;
      WRITEREG  <= wreg_nxt;
      READREG1  <= rr1_nxt;
      READREG2  <= rr2_nxt;
    end
  end

  // Next-state sequencing per opcode
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          case (CMD_OP)
            OP_MOV:  state_nxt = WR1;
            OP_COPY: state_nxt = RD;
`ifdef SEQ_SWAP_EN
            OP_SWAP: state_nxt = RD;
`else
            OP_SWAP: state_nxt = FIN;
`endif
            default: state_nxt = CLR;
          endcase
        end
      end
      RD:  state_nxt = CAP;
      CAP: state_nxt = WR1;
`ifdef SEQ_SWAP_EN
      WR1: state_nxt = (op_q == OP_SWAP) ? WR2 : FIN;
      WR2: state_nxt = FIN;
`else
      WR1: state_nxt = FIN;
`endif
      CLR: state_nxt = (clr_cnt == CLR_LAST) ? FIN : CLR;
      FIN: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, decoded from the next state
  always_comb begin
    ready_nxt   = (state_nxt == IDLE);
    busy_nxt    = (state_nxt != IDLE);
    done_nxt    = (state_nxt == FIN);
`ifdef SEQ_SWAP_EN
    err_nxt     = 1'b0;
`else
    err_nxt     = (state_nxt == FIN) && (cur_op == OP_SWAP);
`endif
    write_nxt   = 1'b0;
    wdata_nxt   = WRITEDATA;
    wreg_nxt    = WRITEREG;
    rr1_nxt     = READREG1;
    rr2_nxt     = READREG2;
    clr_cnt_nxt = clr_cnt;
    if (accept)
      clr_cnt_nxt = '0;
    else if ((state == CLR) && (clr_cnt != CLR_LAST))
      clr_cnt_nxt = clr_cnt + 3'd1;
    case (state_nxt)
      RD: begin
`ifdef SEQ_SWAP_EN
        if (cur_op == OP_SWAP) begin
          rr1_nxt = cur_dest;
          rr2_nxt = cur_src;
        end else begin
          rr1_nxt = cur_src;
        end
`else
        rr1_nxt = cur_src;
`endif
      end
      WR1: begin
        write_nxt = 1'b1;
        wreg_nxt  = cur_dest;
        if (cur_op == OP_MOV)
          wdata_nxt = cur_imm;
`ifdef SEQ_SWAP_EN
        else if (cur_op == OP_SWAP)
          wdata_nxt = cap2_val;
`endif
        else
          wdata_nxt = cap1_val;
      end
`ifdef SEQ_SWAP_EN
      WR2: begin
        write_nxt = 1'b1;
        wreg_nxt  = src_q;
        wdata_nxt = cap1_q;
      end
`endif
      CLR: begin
        write_nxt = 1'b1;
        wreg_nxt  = ADDR_W'(clr_cnt_nxt);
        wdata_nxt = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_reg_access_seq.sv
// Bench for reg_access_seq: a behavioural register file answers the DUT,
// directed commands push expected WRITE/DONE events into a queue, and a
// monitor pops and compares them, including latency from acceptance.
module tb_reg_access_seq;

  localparam int DW = 8;
  localparam int AW = 3;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          CMD_VALID = 1'b0;
  logic          CMD_READY;
  logic [1:0]    CMD_OP = 2'b00;
  logic [AW-1:0] CMD_DEST = '0;
  logic [AW-1:0] CMD_SRC = '0;
  logic [DW-1:0] CMD_IMM = '0;
  logic          BUSY, DONE, ERR, WRITE;
  logic [DW-1:0] WRITEDATA;
  logic [AW-1:0] WRITEREG, READREG1, READREG2;
  logic [DW-1:0] REGOUT1, REGOUT2;

  logic [DW-1:0] rf [0:7];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;

  typedef struct {
    bit            is_done;
    int            k;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            err;
  } exp_t;
  exp_t exp_q[$];

  reg_access_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .CLK(CLK), .RESET(RESET), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .CMD_DEST(CMD_DEST), .CMD_SRC(CMD_SRC), .CMD_IMM(CMD_IMM),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .WRITE(WRITE), .WRITEDATA(WRITEDATA),
    .WRITEREG(WRITEREG), .READREG1(READREG1), .READREG2(READREG2),
    .REGOUT1(REGOUT1), .REGOUT2(REGOUT2)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Register file responder: synchronous write, asynchronous read
  always @(posedge CLK) if (WRITE) rf[WRITEREG] <= WRITEDATA;
  assign REGOUT1 = rf[READREG1];
  assign REGOUT2 = rf[READREG2];

  // Monitor: pop and compare on every WRITE or DONE the DUT presents
  always @(negedge CLK) begin
    if (CMD_VALID && CMD_READY) last_acc = cyc;
    if (WRITE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg=%0d data=%0d, want no write", WRITEREG, WRITEDATA);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (e.is_done || e.addr != WRITEREG || e.data != WRITEDATA || (cyc - last_acc) != e.k
            || !BUSY || CMD_READY) begin
          errors++;
          $display("FAIL write: got reg=%0d data=%0d at=+%0d busy=%b rdy=%b, want done=%0b reg=%0d data=%0d at=+%0d busy=1 rdy=0",
                   WRITEREG, WRITEDATA, cyc - last_acc, BUSY, CMD_READY, e.is_done, e.addr, e.data, e.k);
        end
      end
    end
    if (DONE) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got done err=%b, want no done", ERR);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (!e.is_done || e.err != ERR || (cyc - last_acc) != e.k || !BUSY) begin
          errors++;
          $display("FAIL done: got err=%b at=+%0d busy=%b, want done=%0b err=%b at=+%0d busy=1",
                   ERR, cyc - last_acc, BUSY, e.is_done, e.err, e.k);
        end
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", nm, got, want);
    end
  endtask

  task automatic push_w(input int k, input int addr, input int data);
    exp_t e;
    e.is_done = 1'b0; e.k = k; e.addr = AW'(addr); e.data = DW'(data); e.err = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_d(input int k, input bit err);
    exp_t e;
    e.is_done = 1'b1; e.k = k; e.addr = '0; e.data = '0; e.err = err;
    exp_q.push_back(e);
  endtask

  // Wait for the scoreboard to drain, bounded
  task automatic drain(input string nm);
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      if (exp_q.size() == 0) break;
    end
    #1;
    chk({nm, "_drained"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Present a command; returns the cycle in which it was accepted
  task automatic issue(input logic [1:0] op, input int dest, input int src, input int imm,
                       input bit hold, output int acc);
    bit got;
    got = 1'b0;
    acc = -1;
    CMD_OP = op; CMD_DEST = AW'(dest); CMD_SRC = AW'(src); CMD_IMM = DW'(imm);
    CMD_VALID = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (CMD_READY) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL accept_timeout: got no CMD_READY in 50 cycles, want acceptance");
    end
    @(posedge CLK); #1;
    if (!hold) CMD_VALID = 1'b0;
  endtask

  task automatic do_reset(input string nm);
    RESET = 1'b1;
    CMD_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk({nm, "_outs_in_reset"},
        {CMD_READY, BUSY, DONE, ERR, WRITE, WRITEDATA, WRITEREG, READREG1, READREG2}, 0);
    @(posedge CLK); #1;
    RESET = 1'b0;
    @(posedge CLK);
    @(negedge CLK);
    chk({nm, "_ready_after_reset"}, {CMD_READY, BUSY}, 2'b10);
    @(posedge CLK); #1;
  endtask

  initial begin
    int a1, a2;
    do_reset("init");

    // MOV r3 = 23
    push_w(1, 3, 23); push_d(2, 1'b0);
    issue(seq_pkg::OP_MOV, 3, 0, 23, 1'b0, a1);
    drain("mov");
    chk("mov_r3", rf[3], 23);

    // MOV r5 = 45, COPY r0 <- r5
    push_w(1, 5, 45); push_d(2, 1'b0);
    issue(seq_pkg::OP_MOV, 5, 0, 45, 1'b0, a1);
    drain("mov_r5");
    push_w(3, 0, 45); push_d(4, 1'b0);
    issue(seq_pkg::OP_COPY, 0, 5, 8'hFF, 1'b0, a1);
    drain("copy");
    chk("copy_r0", rf[0], 45);
    chk("copy_r5_kept", rf[5], 45);

    // SWAP r1 <-> r4
    push_w(1, 1, 50); push_d(2, 1'b0);
    issue(seq_pkg::OP_MOV, 1, 0, 50, 1'b0, a1);
    push_w(1, 4, 55); push_d(2, 1'b0);
    issue(seq_pkg::OP_MOV, 4, 0, 55, 1'b0, a1);
    drain("mov_r1_r4");
`ifdef SEQ_SWAP_EN
    push_w(3, 1, 55); push_w(4, 4, 50); push_d(5, 1'b0);
    issue(seq_pkg::OP_SWAP, 1, 4, 0, 1'b0, a1);
    drain("swap");
    chk("swap_r1", rf[1], 55);
    chk("swap_r4", rf[4], 50);
`else
    push_d(1, 1'b1);
    issue(seq_pkg::OP_SWAP, 1, 4, 0, 1'b0, a1);
    drain("swap_rej");
    chk("swap_rej_r1", rf[1], 50);
    chk("swap_rej_r4", rf[4], 55);
`endif

    // Load all registers, then CLEAR
    for (int i = 0; i < 8; i++) begin
      push_w(1, i, 8'h10 + i); push_d(2, 1'b0);
      issue(seq_pkg::OP_MOV, i, 0, 8'h10 + i, 1'b0, a1);
    end
    drain("load1");
    for (int i = 0; i < 8; i++) push_w(1 + i, i, 0);
    push_d(9, 1'b0);
    issue(seq_pkg::OP_CLEAR, 0, 0, 0, 1'b0, a1);
    drain("clear");
    for (int i = 0; i < 8; i++) chk($sformatf("clear_r%0d", i), rf[i], 0);

    // CLEAR aborted by reset during its third write cycle
    for (int i = 0; i < 8; i++) begin
      push_w(1, i, 8'hA0 + i); push_d(2, 1'b0);
      issue(seq_pkg::OP_MOV, i, 0, 8'hA0 + i, 1'b0, a1);
    end
    drain("load2");
    push_w(1, 0, 0); push_w(2, 1, 0); push_w(3, 2, 0);
    issue(seq_pkg::OP_CLEAR, 0, 0, 0, 1'b0, a1);
    repeat (2) @(posedge CLK);
    #1;
    do_reset("abort");
    repeat (12) @(posedge CLK);
    #1;
    chk("abort_queue_empty", exp_q.size(), 0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) chk($sformatf("abort_r%0d", i), rf[i], 0);
    for (int i = 3; i < 8; i++) chk($sformatf("abort_r%0d", i), rf[i], 8'hA0 + i);

    // CMD_VALID held high across two MOVs
    push_w(1, 6, 66); push_d(2, 1'b0);
    push_w(1, 7, 77); push_d(2, 1'b0);
    issue(seq_pkg::OP_MOV, 6, 0, 66, 1'b1, a1);
    issue(seq_pkg::OP_MOV, 7, 0, 77, 1'b0, a2);
    drain("held_valid");
    chk("held_valid_gap", a2 - a1, 3);
    chk("held_r6", rf[6], 66);
    chk("held_r7", rf[7], 77);

    // COPY with SRC == DEST
    push_w(1, 2, 8'h5A); push_d(2, 1'b0);
    issue(seq_pkg::OP_MOV, 2, 0, 8'h5A, 1'b0, a1);
    push_w(3, 2, 8'h5A); push_d(4, 1'b0);
    issue(seq_pkg::OP_COPY, 2, 2, 0, 1'b0, a1);
    drain("copy_same");
    chk("copy_same_r2", rf[2], 8'h5A);

    repeat (3) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
